// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: op_e (MULT/MULTU/DIV/DIVU as seen on the op port), state_e (engine FSM).
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // op[1] selects divide, op[0] selects unsigned.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Shared iterative multiply/divide engine producing HI/LO for the CPU datapath.
// Latency: WIDTH+2 cycles start->done; divide-by-zero reports done 1 cycle after start.
// Backpressure: busy high outside IDLE; start while busy is dropped, never queued.
// Ports: clk, reset (async, active-high); start/op/a/b request (sampled in IDLE only);
//        busy, done (1-cycle pulse), div_zero (pulse with done); hi/lo result
//        (hi = upper product / remainder, lo = lower product / quotient).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc: multiply = {partial product, remaining multiplier bits};
  //      divide   = {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic               div_q, div_d;
  logic               neg_lo_q, neg_lo_d; // product / quotient sign
  logic               neg_hi_q, neg_hi_d; // remainder sign (follows dividend)
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic               a_neg, b_neg;
  op_e                op_in;

  always_comb begin
    op_in     = op_e'(op);
    a_neg     = op_is_signed(op_in) & a[WIDTH-1];
    b_neg     = op_is_signed(op_in) & b[WIDTH-1];
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    prod_fix  = neg_lo_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_is_div(op_in) && (b == '0)) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            dz_d     = 1'b0;
            div_d    = op_is_div(op_in);
            acc_d    = {{WIDTH{1'b0}}, neg_if(a, a_neg)};
            opnd_d   = neg_if(b, b_neg);
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (div_q) begin
          // Restoring step: keep the trial subtraction only if it did not borrow.
          if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          hi_d = neg_if(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
          lo_d = neg_if(acc_q[WIDTH-1:0], neg_lo_q);
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        dz_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) & dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): driver pushes expected results,
// monitor pops and compares on every done pulse.
// Reference model uses plain 64-bit arithmetic.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          exp_dones = 0;
  int          seen_dones = 0;
  logic [31:0] mhi = '0, mlo = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    h  = mhi;
    l  = mlo;
    case (o)
      2'b00: begin p = sx * sy; {h, l} = p; end
      2'b01: begin p = {32'h0, x} * {32'h0, y}; {h, l} = p; end
      2'b10: begin
        if (y == 0) dz = 1'b1;
        else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (y == 0) dz = 1'b1;
        else begin l = x / y; h = x % y; end
      end
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    wait_idle();
    model(o, x, y, e.hi, e.lo, e.dz);
    e.cyc = cyc + 1 + (e.dz ? 0 : 33);
    if (!e.dz) begin mhi = e.hi; mlo = e.lo; end
    sb.push_back(e);
    exp_dones++;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  // Monitor: compares each done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (done === 1'b1) begin
        seen_dones++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
        end
      end else begin
        if (div_zero !== 1'b0) chk("div_zero_without_done", 64'(div_zero), 64'(0));
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          chk("missing_done", 64'(cyc), 64'(sb[0].cyc));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x, y;
    logic [1:0]  o;
    int          n;

    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div_zero", 64'(div_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    issue(OP_MULT,  32'hFFFFFFFD, 32'd7);
    issue(OP_MULTU, 32'hFFFFFFFD, 32'd7);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2);
    issue(OP_DIVU,  32'hFFFFFFF9, 32'd2);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF);
    issue(OP_DIVU,  32'h12345678, 32'd0);
    issue(OP_DIV,   32'h00000005, 32'd0);
    issue(OP_MULT,  32'h80000000, 32'h80000000);
    issue(OP_DIV,   32'h00000007, 32'hFFFFFFFE);

    // start while busy must be dropped.
    issue(OP_MULT, 32'd1234, 32'hFFFFFF00);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd99; b = 32'd77;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a divide: no done, outputs back to zero.
    issue(OP_DIV, 32'hDEADBEEF, 32'd13);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    sb.delete();
    exp_dones--;
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(OP_MULTU, 32'd6, 32'd7);

    // Randomized operations, including zero and -1 divisors and MIN dividends.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      case ($urandom_range(0, 9))
        0:       y = 32'd0;
        1:       y = 32'hFFFFFFFF;
        2:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      issue(o, x, y);
    end

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    chk("done_count", 64'(seen_dones), 64'(exp_dones));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that supplies the HI/LO write data for the multicycle CPU datapath. It replaces the separate fixed-width multiplier and divider with one shared engine. The engine supports signed and unsigned modes, a start/done handshake, a busy indication and single-cycle divide-by-zero detection. The control FSM issues `start`, stalls on `busy`, and loads HI/LO on `done`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; products and remainders are 2·`WIDTH` / `WIDTH` bits wide.
- `CNT_W`, $clog2(`WIDTH`+1): width of the iteration counter.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation, sampled with `start`:
  - 00 MULT
  - 01 MULTU
  - 10 DIV
  - 11 DIVU
- `a`  in  `WIDTH`  multiplicand / dividend; sampled with `start`.
- `b`  in  `WIDTH`  multiplier / divisor; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: result valid.
- `div_zero`  out  1  one-cycle pulse coincident with `done`; divisor was 0.
- `hi`  out  `WIDTH`  result high half:
  - multiply: upper product bits
  - divide: remainder
- `lo`  out  `WIDTH`  result low half:
  - multiply: lower product bits
  - divide: quotient

## Operation
States: IDLE, CALC, FIX, DONE.

IDLE:
- `start`=1 latches `op`, `a`, `b` and enters CALC.
- Exception: a DIV/DIVU request with `b`==0 goes directly to DONE with `div_zero`=1.
- Signed ops convert both operands to magnitudes and record the result signs:
  - product sign = sign(a) XOR sign(b)
  - quotient sign = sign(a) XOR sign(b)
  - remainder sign = sign(a)
- The iteration counter is loaded with `WIDTH`.

CALC, one iteration per cycle; the counter decrements and the state moves to FIX after the iteration with counter==1:
- Multiply: radix-2 shift-add on a 2·`WIDTH` accumulator.
- Divide: restoring division, one quotient bit per cycle, with a `WIDTH`+1-bit partial remainder.

FIX, one cycle:
- Negate product, quotient and remainder according to the recorded signs (two's complement).
- Write `hi`/`lo`.
- Go to DONE.

DONE, one cycle:
- `done`=1.
- `div_zero` reflects the zero-divisor case.
- Return to IDLE.

Arithmetic rules:
- Division truncates toward zero; the remainder takes the sign of the dividend.
- Signed MIN / −1 gives `lo`=MIN and `hi`=0, with no flag.
- On divide-by-zero, `hi`/`lo` are not updated and keep their previous values.

`start` while `busy` is ignored and produces no queued request.

## Timing
- Reset values:
  - state = IDLE
  - `busy`=0, `done`=0, `div_zero`=0
  - `hi`=0, `lo`=0
  - counter and accumulators = 0
- Normal op: `start` sampled at edge k.
  - `busy` is high from after edge k.
  - `hi`/`lo` update at edge k+`WIDTH`+1.
  - `done` is high in the cycle after edge k+`WIDTH`+1, i.e. `WIDTH`+2 cycles after `start`.
  - `busy` falls at edge k+`WIDTH`+2.
- Divide-by-zero: `done`/`div_zero` are high in the cycle after edge k. `busy` is high for that one cycle only.
- Back-to-back: a new `start` may be presented in the cycle `done` is high. It is accepted at the edge where DONE→IDLE? No — it is accepted only in IDLE, so the earliest accepted `start` is the cycle after `done`.
- `hi`/`lo` are stable from the `done` cycle until the next FIX.
- Reset mid-operation: immediately IDLE, all outputs return to reset values, and no `done` is produced.

## Structure
- Package `muldiv_pkg` contains:
  - the `op` encoding constants/enum (MULT, MULTU, DIV, DIVU)
  - the state enum (IDLE, CALC, FIX, DONE)
- The CPU control FSM imports `muldiv_pkg` for the `op` encodings.
- Single module, no sub-modules. The shared magnitude/negate logic is a local function, not a separate block.

## Test plan
All scenarios use `WIDTH`=32.
- MULT, a=0xFFFFFFFD (−3), b=7 → `done` 34 cycles after `start`; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `div_zero`=0.
- MULTU, a=0xFFFFFFFD, b=7 → `hi`=0x00000006, `lo`=0xFFFFFFEB.
- DIV, a=−7 (0xFFFFFFF9), b=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIVU with the same operands → `lo`=0x7FFFFFFC, `hi`=0x00000001.
- DIV, a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0. Then DIVU with b=0 → `done` and `div_zero` high one cycle after `start`, and `hi`/`lo` unchanged.
- `start` pulsed again at cycle 5 of a MULT with different operands → ignored; only the first result is produced and exactly one `done` pulse occurs.
- `reset` asserted at cycle 10 of a DIV → `busy`=0 and `hi`=`lo`=0 immediately, with no `done`. A subsequent MULTU 6×7 → `lo`=42, `hi`=0.
